writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/riscv_defines.sv | 18 +
 rtl/load_formatter.sv | 31 +++
 rtl/writeback_stage.sv | 94 +++++++++
 tb/tb_writeback_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared widths, load-type encodings and writeback FSM states
package riscv_defines;

    localparam int ADDR_WIDTH = 5;
    localparam int WORD_WIDTH = 32;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - combinational byte/halfword lane select and sign/zero extension
module load_formatter #(
    parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH
) (
    input  logic [WORD_WIDTH-1:0] rdata,
    input  logic [2:0]            load_type,
    input  logic [1:0]            lsb,
    output logic [WORD_WIDTH-1:0] word
);
    import riscv_defines::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // lsb[0] is deliberately ignored for halfwords: misaligned halves are not split
    assign byte_sel = rdata[{lsb, 3'b000} +: 8];
    assign half_sel = rdata[{lsb[1], 4'b0000} +: 16];

    // Extend the selected lane; anything not a byte/half type is a full-word load
    always_comb begin
        word = rdata;
        case (load_type)
            LD_LB:   word = {{(WORD_WIDTH-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  word = {{(WORD_WIDTH-8){1'b0}}, byte_sel};
            LD_LH:   word = {{(WORD_WIDTH-16){half_sel[15]}}, half_sel};
            LD_LHU:  word = {{(WORD_WIDTH-16){1'b0}}, half_sel};
            default: word = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - register writeback with load wait FSM; WB_FWD_EN adds bypass outputs
module writeback_stage #(
    parameter int ADDR_WIDTH = riscv_defines::ADDR_WIDTH,
    parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic [WORD_WIDTH-1:0] ex_result_i,
    input  logic                  ex_is_load_i,
    input  logic [2:0]            ex_load_type_i,
    input  logic [1:0]            ex_addr_lsb_i,
    input  logic                  mem_rvalid_i,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i,
    output logic [ADDR_WIDTH-1:0] write_addr_o,
    output logic [WORD_WIDTH-1:0] write_data_o,
    output logic                  write_en_o
`ifdef WB_FWD_EN
    ,
    output logic                  fwd_valid_o,
    output logic [ADDR_WIDTH-1:0] fwd_addr_o,
    output logic [WORD_WIDTH-1:0] fwd_data_o
`endif
);
    import riscv_defines::*;

    wb_state_e             state;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [2:0]            type_q;
    logic [1:0]            lsb_q;
    logic [WORD_WIDTH-1:0] load_word;

    assign ex_ready_o = (state == IDLE);

    load_formatter #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_load_formatter (
        .rdata    (mem_rdata_i),
        .load_type(type_q),
        .lsb      (lsb_q),
        .word     (load_word)
    );

    // Accept/writeback FSM; address and data only move when a real write happens
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state        <= IDLE;
            write_en_o   <= 1'b0;
            write_addr_o <= '0;
            write_data_o <= '0;
            rd_q         <= '0;
            type_q       <= LD_LW;
            lsb_q        <= 2'b00;
        end else begin
            write_en_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid_i) begin
                        rd_q   <= ex_rd_addr_i;
                        type_q <= ex_load_type_i;
                        lsb_q  <= ex_addr_lsb_i;
                        if (ex_is_load_i) begin
                            state <= WAIT_MEM;
                        end else if (ex_rd_addr_i != '0) begin
                            write_en_o   <= 1'b1;
                            write_addr_o <= ex_rd_addr_i;
                            write_data_o <= ex_result_i;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid_i) begin
                        state <= IDLE;
                        if (rd_q != '0) begin
                            write_en_o   <= 1'b1;
                            write_addr_o <= rd_q;
                            write_data_o <= load_word;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid_o = write_en_o;
    assign fwd_addr_o  = write_addr_o;
    assign fwd_data_o  = write_data_o;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_rd_addr_i;
    logic [31:0] ex_result_i;
    logic        ex_is_load_i;
    logic [2:0]  ex_load_type_i;
    logic [1:0]  ex_addr_lsb_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [4:0]  write_addr_o;
    logic [31:0] write_data_o;
    logic        write_en_o;
`ifdef WB_FWD_EN
    logic        fwd_valid_o;
    logic [4:0]  fwd_addr_o;
    logic [31:0] fwd_data_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .ex_valid_i    (ex_valid_i),
        .ex_ready_o    (ex_ready_o),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_result_i   (ex_result_i),
        .ex_is_load_i  (ex_is_load_i),
        .ex_load_type_i(ex_load_type_i),
        .ex_addr_lsb_i (ex_addr_lsb_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .write_addr_o  (write_addr_o),
        .write_data_o  (write_data_o),
        .write_en_o    (write_en_o)
`ifdef WB_FWD_EN
        ,
        .fwd_valid_o   (fwd_valid_o),
        .fwd_addr_o    (fwd_addr_o),
        .fwd_data_o    (fwd_data_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_write(input string tag, input logic en, input logic [4:0] addr,
                               input logic [31:0] data);
        check({tag, "_en"}, {31'b0, write_en_o}, {31'b0, en});
        check({tag, "_addr"}, {27'b0, write_addr_o}, {27'b0, addr});
        check({tag, "_data"}, write_data_o, data);
`ifdef WB_FWD_EN
        check({tag, "_fwd_v"}, {31'b0, fwd_valid_o}, {31'b0, en});
        check({tag, "_fwd_a"}, {27'b0, fwd_addr_o}, {27'b0, addr});
        check({tag, "_fwd_d"}, fwd_data_o, data);
`endif
    endtask

    // Accept a load, hold rvalid low for extra_wait cycles, then respond and check the write
    task automatic do_load(input string tag, input logic [2:0] ltype, input logic [1:0] lsb,
                           input logic [4:0] rd, input logic [31:0] rdata, input int extra_wait,
                           input logic exp_en, input logic [4:0] exp_addr,
                           input logic [31:0] exp_data);
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_load_type_i = ltype;
        ex_addr_lsb_i = lsb; ex_rd_addr_i = rd; ex_result_i = 32'hA5A5A5A5;
        check({tag, "_rdy_acc"}, {31'b0, ex_ready_o}, 32'd1);
        step();
        ex_valid_i = 1'b0; ex_is_load_i = 1'b0; mem_rdata_i = rdata;
        for (int i = 0; i < extra_wait; i++) begin
            check({tag, "_rdy_wait"}, {31'b0, ex_ready_o}, 32'd0);
            check({tag, "_en_wait"}, {31'b0, write_en_o}, 32'd0);
            step();
        end
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        mem_rdata_i = 32'h0;
        check_write(tag, exp_en, exp_addr, exp_data);
        check({tag, "_rdy_done"}, {31'b0, ex_ready_o}, 32'd1);
        step();
        check({tag, "_en_after"}, {31'b0, write_en_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd7;
        ex_result_i = 32'hFFFF_FFFF; ex_load_type_i = 3'b010; ex_addr_lsb_i = 2'b00;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;

        // Reset with a simultaneous accept and rvalid: reset must win
        @(negedge clk);
        step();
        check_write("reset", 1'b0, 5'd0, 32'h0);
        check("reset_rdy", {31'b0, ex_ready_o}, 32'd1);
        rst_i = 1'b0; ex_valid_i = 1'b0; ex_is_load_i = 1'b0; mem_rvalid_i = 1'b0;
        mem_rdata_i = 32'h0;
        step();
        check_write("post_reset", 1'b0, 5'd0, 32'h0);

        // Single ALU op: one-cycle write pulse, then hold
        ex_valid_i = 1'b1; ex_rd_addr_i = 5'd5; ex_result_i = 32'h12345678;
        step();
        ex_valid_i = 1'b0;
        check_write("alu5", 1'b1, 5'd5, 32'h12345678);
        step();
        check_write("alu5_hold", 1'b0, 5'd5, 32'h12345678);

        // Back-to-back ALU ops
        ex_valid_i = 1'b1; ex_rd_addr_i = 5'd1; ex_result_i = 32'h0000_0011;
        check("b2b_rdy1", {31'b0, ex_ready_o}, 32'd1);
        step();
        check_write("b2b1", 1'b1, 5'd1, 32'h0000_0011);
        ex_rd_addr_i = 5'd2; ex_result_i = 32'h0000_0022;
        check("b2b_rdy2", {31'b0, ex_ready_o}, 32'd1);
        step();
        check_write("b2b2", 1'b1, 5'd2, 32'h0000_0022);
        ex_rd_addr_i = 5'd3; ex_result_i = 32'h0000_0033;
        check("b2b_rdy3", {31'b0, ex_ready_o}, 32'd1);
        step();
        check_write("b2b3", 1'b1, 5'd3, 32'h0000_0033);
        ex_valid_i = 1'b0;
        step();
        check_write("b2b_idle", 1'b0, 5'd3, 32'h0000_0033);

        // rvalid while idle is ignored
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        step();
        mem_rvalid_i = 1'b0;
        check_write("idle_rvalid", 1'b0, 5'd3, 32'h0000_0033);

        // Loads with hand-formatted data
        do_load("lb3",  3'b000, 2'd3, 5'd10, 32'h80FF0102, 3, 1'b1, 5'd10, 32'hFFFFFF80);
        do_load("lbu3", 3'b100, 2'd3, 5'd11, 32'h80FF0102, 3, 1'b1, 5'd11, 32'h00000080);
        do_load("lb2",  3'b000, 2'd2, 5'd12, 32'h80FF0102, 0, 1'b1, 5'd12, 32'hFFFFFFFF);
        do_load("lb0",  3'b000, 2'd0, 5'd13, 32'h80FF0102, 1, 1'b1, 5'd13, 32'h00000002);
        do_load("lh2",  3'b001, 2'd2, 5'd14, 32'h80017FFF, 2, 1'b1, 5'd14, 32'hFFFF8001);
        do_load("lhu1", 3'b101, 2'd1, 5'd15, 32'h80017FFF, 2, 1'b1, 5'd15, 32'h00007FFF);
        do_load("lh1",  3'b001, 2'd1, 5'd16, 32'h12348000, 0, 1'b1, 5'd16, 32'hFFFF8000);
        do_load("lhu3", 3'b101, 2'd3, 5'd17, 32'h9ABC1234, 0, 1'b1, 5'd17, 32'h00009ABC);
        do_load("lw",   3'b010, 2'd1, 5'd18, 32'hDEADBEEF, 1, 1'b1, 5'd18, 32'hDEADBEEF);
        do_load("undef",3'b111, 2'd3, 5'd19, 32'h80FF0102, 0, 1'b1, 5'd19, 32'h80FF0102);

        // rd=0: no write for ALU or load, addr/data hold
        ex_valid_i = 1'b1; ex_rd_addr_i = 5'd0; ex_result_i = 32'hDEADBEEF;
        step();
        ex_valid_i = 1'b0;
        check_write("rd0_alu", 1'b0, 5'd19, 32'h80FF0102);
        check("rd0_alu_rdy", {31'b0, ex_ready_o}, 32'd1);
        do_load("rd0_ld", 3'b010, 2'd0, 5'd0, 32'h1111_2222, 2, 1'b0, 5'd19, 32'h80FF0102);

        // Reset during WAIT_MEM abandons the load
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_load_type_i = 3'b010; ex_rd_addr_i = 5'd9;
        step();
        ex_valid_i = 1'b0; ex_is_load_i = 1'b0;
        check("rst_wait_rdy0", {31'b0, ex_ready_o}, 32'd0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst_wait_rdy1", {31'b0, ex_ready_o}, 32'd1);
        check_write("rst_wait", 1'b0, 5'd0, 32'h0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        step();
        mem_rvalid_i = 1'b0;
        check_write("rst_late_rvalid", 1'b0, 5'd0, 32'h0);

        // Reset coincident with rvalid in WAIT_MEM
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd8;
        step();
        ex_valid_i = 1'b0; ex_is_load_i = 1'b0;
        rst_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        step();
        rst_i = 1'b0; mem_rvalid_i = 1'b0;
        check_write("rst_vs_rvalid", 1'b0, 5'd0, 32'h0);
        check("rst_vs_rvalid_rdy", {31'b0, ex_ready_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
